ddr_burst_arbiter: RTL and testbench

DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

---
 rtl/ddr_burst_arbiter.sv | 156 +++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_arbiter.sv
// Grants one of CH_NUM channels a DDR burst, sequences IDLE->GRANT->BUSY and routes strobes/data/done.
// Latency: request to m_req 1 cycle, m_done to ch_done 1 cycle; m_ready=0 holds new grants off in IDLE.
module ddr_burst_arbiter #(
    parameter int CH_NUM   = 2,
    parameter int AW       = 32,
    parameter int LW       = 10,
    parameter int DW       = 64,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic                 ui_clk,
    input  logic                 ui_rst,
    input  logic [CH_NUM-1:0]    ch_req,
    input  logic [CH_NUM*AW-1:0] ch_addr,
    input  logic [CH_NUM*LW-1:0] ch_len,
    input  logic [CH_NUM*DW-1:0] ch_wdata,
    output logic [CH_NUM-1:0]    ch_grant,
    output logic [CH_NUM-1:0]    ch_strb,
    output logic [CH_NUM-1:0]    ch_done,
    output logic                 m_req,
    output logic [AW-1:0]        m_addr,
    output logic [LW-1:0]        m_len,
    input  logic                 m_ready,
    input  logic                 m_strb,
    output logic [DW-1:0]        m_wdata,
    input  logic                 m_done,
    output logic                 timeout_err
);

    localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    state_t              state_q;
    logic [GW-1:0]       g_q;
    logic [GW-1:0]       last_g_q;
    logic [AW-1:0]       m_addr_q;
    logic [LW-1:0]       m_len_q;
    logic                m_req_q;
    logic [CH_NUM-1:0]   grant_q;
    logic [CH_NUM-1:0]   done_q;
    logic                timeout_q;
    logic [15:0]         wdog_q;

    logic [GW-1:0]       win_d;
    logic [CH_NUM-1:0]   win_oh_d;
    logic [AW-1:0]       addr_d;
    logic [LW-1:0]       len_d;
    logic                wdog_hit;
    logic [DW-1:0]       wdata_c;
    int                  dist_c;
    int                  best_c;

    // Winner is the requester at the smallest distance from the search start.
    always_comb begin
        win_d    = '0;
        win_oh_d = '0;
        addr_d   = '0;
        len_d    = '0;
        dist_c   = 0;
        best_c   = CH_NUM;
        for (int i = 0; i < CH_NUM; i++) begin
            dist_c = (ARB_MODE == 1) ? i : (i + CH_NUM - 1 - int'(last_g_q)) % CH_NUM;
            if (ch_req[i] && (dist_c < best_c)) begin
                best_c = dist_c;
                win_d  = GW'(i);
            end
        end
        for (int i = 0; i < CH_NUM; i++) begin
            if (win_d == GW'(i)) begin
                win_oh_d[i] = 1'b1;
                addr_d      = ch_addr[i*AW +: AW];
                len_d       = ch_len[i*LW +: LW];
            end
        end
    end

    assign wdog_hit = (TIMEOUT != 0) && (wdog_q == 16'(TIMEOUT - 1));

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            state_q   <= IDLE;
            g_q       <= '0;
            last_g_q  <= GW'(CH_NUM - 1);
            m_addr_q  <= '0;
            m_len_q   <= '0;
            m_req_q   <= 1'b0;
            grant_q   <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            m_req_q <= 1'b0;
            done_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (m_ready && (|ch_req)) begin
                        g_q      <= win_d;
                        m_addr_q <= addr_d;
                        m_len_q  <= len_d;
                        grant_q  <= win_oh_d;
                        m_req_q  <= (len_d != '0);
                        done_q   <= (len_d == '0) ? win_oh_d : '0;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    wdog_q <= '0;
                    if (m_len_q == '0) begin
                        // Empty burst still rotates priority so it cannot monopolise the grant.
                        grant_q  <= '0;
                        last_g_q <= g_q;
                        state_q  <= IDLE;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_done || wdog_hit) begin
                        done_q   <= grant_q;
                        grant_q  <= '0;
                        last_g_q <= g_q;
                        state_q  <= IDLE;
                        if (!m_done) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wdata_c = '0;
        if (state_q != IDLE) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (grant_q[i]) begin
                    wdata_c = ch_wdata[i*DW +: DW];
                end
            end
        end
    end

    assign ch_grant    = grant_q;
    assign ch_done     = done_q;
    assign ch_strb     = (state_q == BUSY) ? (grant_q & {CH_NUM{m_strb}}) : '0;
    assign m_req       = m_req_q;
    assign m_addr      = m_addr_q;
    assign m_len       = m_len_q;
    assign m_wdata     = wdata_c;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed and randomized bench for ddr_burst_arbiter: round-robin instance and fixed-priority/watchdog instance.
module tb_ddr_burst_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   ch_req = '0;
    logic [63:0]  ch_addr = '0;
    logic [19:0]  ch_len = '0;
    logic [127:0] ch_wdata = '0;
    logic         m_ready = 1'b0;
    logic         m_strb = 1'b0;
    logic         m_done = 1'b0;

    logic [1:0]  rr_grant, rr_strb, rr_done, fp_grant, fp_strb, fp_done;
    logic        rr_mreq, fp_mreq, rr_to, fp_to;
    logic [31:0] rr_maddr, fp_maddr;
    logic [9:0]  rr_mlen, fp_mlen;
    logic [63:0] rr_wdata, fp_wdata;

    logic        sel = 1'b0;
    logic [1:0]  o_grant, o_strb, o_done;
    logic        o_mreq, o_to;
    logic [31:0] o_maddr;
    logic [9:0]  o_mlen;
    logic [63:0] o_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr_burst_arbiter #(.CH_NUM(2), .AW(32), .LW(10), .DW(64), .ARB_MODE(0), .TIMEOUT(0)) dut_rr (
        .ui_clk(clk), .ui_rst(rst), .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
        .ch_wdata(ch_wdata), .ch_grant(rr_grant), .ch_strb(rr_strb), .ch_done(rr_done),
        .m_req(rr_mreq), .m_addr(rr_maddr), .m_len(rr_mlen), .m_ready(m_ready),
        .m_strb(m_strb), .m_wdata(rr_wdata), .m_done(m_done), .timeout_err(rr_to));

    ddr_burst_arbiter #(.CH_NUM(2), .AW(32), .LW(10), .DW(64), .ARB_MODE(1), .TIMEOUT(50)) dut_fp (
        .ui_clk(clk), .ui_rst(rst), .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
        .ch_wdata(ch_wdata), .ch_grant(fp_grant), .ch_strb(fp_strb), .ch_done(fp_done),
        .m_req(fp_mreq), .m_addr(fp_maddr), .m_len(fp_mlen), .m_ready(m_ready),
        .m_strb(m_strb), .m_wdata(fp_wdata), .m_done(m_done), .timeout_err(fp_to));

    assign o_grant = sel ? fp_grant : rr_grant;
    assign o_strb  = sel ? fp_strb  : rr_strb;
    assign o_done  = sel ? fp_done  : rr_done;
    assign o_mreq  = sel ? fp_mreq  : rr_mreq;
    assign o_to    = sel ? fp_to    : rr_to;
    assign o_maddr = sel ? fp_maddr : rr_maddr;
    assign o_mlen  = sel ? fp_mlen  : rr_mlen;
    assign o_wdata = sel ? fp_wdata : rr_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] oh(input int g);
        return 64'(1) << g;
    endfunction

    function automatic logic [31:0] addr_of(input int c);
        return (c == 0) ? ch_addr[31:0] : ch_addr[63:32];
    endfunction

    function automatic logic [9:0] len_of(input int c);
        return (c == 0) ? ch_len[9:0] : ch_len[19:10];
    endfunction

    function automatic logic [63:0] wd_of(input int c);
        return (c == 0) ? ch_wdata[63:0] : ch_wdata[127:64];
    endfunction

    // Reference round-robin: first requester after the last owner, wrapping.
    function automatic int rr_pick(input logic [1:0] pat, input int last);
        for (int k = 1; k <= 2; k++) begin
            if (pat[(last + k) % 2]) return (last + k) % 2;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1; ch_req = '0; m_ready = 1'b1; m_strb = 1'b0; m_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for m_req, checks the grant, runs nstrb strobes then m_done, checks ch_done.
    task automatic run_burst(input int g, input logic [31:0] ea, input logic [9:0] el,
                             input int nstrb, input bit drop_req);
        int  w = 0;
        bit  seen = 1'b0;
        while (!seen && w < 40) begin
            @(negedge clk);
            w++;
            if (o_mreq === 1'b1) seen = 1'b1;
        end
        chk("mreq_seen", 64'(seen), 64'(1));
        if (!seen) return;
        chk("mreq_latency", 64'(w), 64'(1));
        chk("grant", 64'(o_grant), oh(g));
        chk("m_addr", 64'(o_maddr), 64'(ea));
        chk("m_len", 64'(o_mlen), 64'(el));
        chk("wdata_grant", o_wdata, wd_of(g));
        if (drop_req) ch_req = '0;
        ch_addr = {$urandom, $urandom};
        ch_len  = {10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023))};
        for (int i = 0; i < nstrb; i++) begin
            @(negedge clk);
            m_strb = 1'b1;
            #1;
            chk("strb_route", 64'(o_strb), oh(g));
            chk("grant_busy", 64'(o_grant), oh(g));
            chk("mreq_once", 64'(o_mreq), 64'(0));
        end
        @(negedge clk);
        m_strb = 1'b0;
        m_done = 1'b1;
        #1;
        chk("strb_off", 64'(o_strb), 64'(0));
        chk("addr_stable", 64'(o_maddr), 64'(ea));
        chk("done_early", 64'(o_done), 64'(0));
        @(negedge clk);
        m_done = 1'b0;
        chk("ch_done", 64'(o_done), oh(g));
        chk("grant_clear", 64'(o_grant), 64'(0));
        chk("wdata_idle", o_wdata, 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(o_grant), 64'(0));
        chk({tag, "_strb"}, 64'(o_strb), 64'(0));
        chk({tag, "_done"}, 64'(o_done), 64'(0));
        chk({tag, "_mreq"}, 64'(o_mreq), 64'(0));
        chk({tag, "_maddr"}, 64'(o_maddr), 64'(0));
        chk({tag, "_mlen"}, 64'(o_mlen), 64'(0));
        chk({tag, "_wdata"}, o_wdata, 64'(0));
        chk({tag, "_to"}, 64'(o_to), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int last;
        int g;
        logic [1:0] pat;
        ch_wdata = {64'hA1A2_A3A4_A5A6_A7A8, 64'h1122_3344_5566_7788};

        // Reset values, strobe/done inputs active to show they are masked.
        rst = 1'b1; m_strb = 1'b1; m_done = 1'b1; ch_req = 2'b11; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0; #1; chk_all_zero("rst_rr");
        sel = 1'b1; #1; chk_all_zero("rst_fp");
        sel = 1'b0;

        // Single request on channel 0, 128 beats.
        do_reset();
        ch_addr[31:0] = 32'h100; ch_len[9:0] = 10'd128;
        ch_req = 2'b01;
        run_burst(0, 32'h100, 10'd128, 128, 1'b1);

        // Round-robin contention, requests held.
        do_reset();
        ch_req = 2'b11;
        for (int b = 0; b < 4; b++) begin
            run_burst(b % 2, addr_of(b % 2), len_of(b % 2), 3, 1'b0);
        end
        ch_req = '0;

        // Zero-length burst on channel 1.
        do_reset();
        ch_len[19:10] = 10'd0;
        ch_req = 2'b10;
        @(negedge clk);
        chk("zl_mreq", 64'(o_mreq), 64'(0));
        chk("zl_done", 64'(o_done), 64'(2'b10));
        chk("zl_grant", 64'(o_grant), 64'(2'b10));
        ch_req = '0;
        @(negedge clk);
        chk("zl_done_after", 64'(o_done), 64'(0));
        chk("zl_grant_after", 64'(o_grant), 64'(0));
        chk("zl_mreq_after", 64'(o_mreq), 64'(0));

        // Reset during BUSY on channel 1, then channel 0 wins first.
        do_reset();
        ch_len = {10'd8, 10'd8};
        ch_req = 2'b10;
        @(negedge clk);
        chk("mr_mreq", 64'(o_mreq), 64'(1));
        chk("mr_grant", 64'(o_grant), 64'(2'b10));
        ch_req = '0;
        @(negedge clk);
        m_strb = 1'b1;
        #1;
        chk("mr_strb", 64'(o_strb), 64'(2'b10));
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mr_rst");
        m_strb = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_no_done", 64'(o_done), 64'(0));
        ch_req = 2'b11;
        run_burst(0, addr_of(0), len_of(0), 2, 1'b1);

        // Fixed priority, both held.
        sel = 1'b1;
        do_reset();
        ch_req = 2'b11;
        for (int b = 0; b < 3; b++) begin
            run_burst(0, addr_of(0), len_of(0), 2, 1'b0);
        end
        ch_req = '0;

        // Watchdog: m_done withheld, done expected 50 cycles after BUSY entry.
        do_reset();
        ch_len[9:0] = 10'd4;
        ch_req = 2'b01;
        @(negedge clk);
        chk("wd_mreq", 64'(o_mreq), 64'(1));
        ch_req = '0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            chk("wd_no_done", 64'(o_done), 64'(0));
            chk("wd_no_err", 64'(o_to), 64'(0));
        end
        @(negedge clk);
        chk("wd_done", 64'(o_done), 64'(2'b01));
        chk("wd_err", 64'(o_to), 64'(1));
        chk("wd_grant", 64'(o_grant), 64'(0));
        @(negedge clk);
        chk("wd_err_sticky", 64'(o_to), 64'(1));
        chk("wd_done_pulse", 64'(o_done), 64'(0));
        // Strobe and done outside BUSY are ignored.
        m_strb = 1'b1; m_done = 1'b1;
        #1;
        chk("idle_strb", 64'(o_strb), 64'(0));
        @(negedge clk);
        chk("idle_done", 64'(o_done), 64'(0));
        m_strb = 1'b0; m_done = 1'b0;
        ch_req = 2'b01;
        run_burst(0, addr_of(0), len_of(0), 3, 1'b1);
        chk("wd_err_kept", 64'(o_to), 64'(1));

        // Randomized round-robin against the reference model.
        sel = 1'b0;
        do_reset();
        last = 1;
        for (int it = 0; it < 24; it++) begin
            int d;
            pat = 2'($urandom_range(1, 3));
            ch_len = {10'($urandom_range(1, 12)), 10'($urandom_range(1, 12))};
            ch_wdata = {$urandom, $urandom, $urandom, $urandom};
            d = $urandom_range(0, 2);
            m_ready = (d == 0);
            ch_req = pat;
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                chk("rnd_not_ready", 64'(o_mreq), 64'(0));
            end
            m_ready = 1'b1;
            g = rr_pick(pat, last);
            run_burst(g, addr_of(g), len_of(g), int'(len_of(g)), 1'b1);
            last = g;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
